// File: rtl/ex_mdu_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mdu_ctrl_if
//  Description : EX-stage <-> multiply/divide unit handshake and result bus.
//  Revision    : 1.0  initial release
// ============================================================================
`ifndef GPR_WIDTH
`define GPR_WIDTH 32
`endif

interface ex_mdu_ctrl_if;
   logic                  start;
   logic [1:0]            op;
   logic [`GPR_WIDTH-1:0] op_a;
   logic [`GPR_WIDTH-1:0] op_b;
   logic                  flush;
   logic                  stall;
   logic                  busy;
   logic                  done;
   logic [`GPR_WIDTH-1:0] result;
   logic                  div_zero;
   logic                  illegal_op;

   modport master (
      output start, op, op_a, op_b, flush,
      input  stall, busy, done, result, div_zero, illegal_op
   );

   modport slave (
      input  start, op, op_a, op_b, flush,
      output stall, busy, done, result, div_zero, illegal_op
   );
endinterface

`default_nettype wire

// File: rtl/ex_mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mdu_ctrl
//  Description : Iterative MUL/MULH/DIV/REM unit that stalls the pipeline.
//                Divider built only when LAPIDO_MDU_DIV_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
`ifndef GPR_WIDTH
`define GPR_WIDTH 32
`endif

module ex_mdu_ctrl (
   input  wire logic    clk,
   input  wire logic    rst,
   ex_mdu_ctrl_if.slave bus
);

   localparam int         c_width = `GPR_WIDTH;
   localparam logic [5:0] c_last  = 6'(c_width - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [5:0]           r_cnt;
   logic                 r_sel_hi;
   logic [c_width-1:0]   r_a;
   logic [c_width-1:0]   r_hi;
   logic [c_width-1:0]   r_lo;
   logic [c_width-1:0]   r_result;
   logic                 r_div_zero;
   logic                 r_illegal;
   logic [c_width-1:0]   w_hi_nxt;
   logic [c_width-1:0]   w_lo_nxt;
   logic [c_width:0]     w_sum;
   logic [c_width-1:0]   w_fast_result;
   logic                 w_accept;
   logic                 w_fast;
   logic                 w_finish;
`ifdef LAPIDO_MDU_DIV_EN
   logic [c_width-1:0]   r_b;
   logic                 r_is_div;
   logic [c_width:0]     w_rem_sh;
   logic [c_width:0]     w_diff;
`endif

   assign w_accept = (r_state == S_IDLE) & bus.start & ~bus.flush;
   assign w_finish = (r_state == S_RUN) & (r_cnt == c_last) & ~bus.flush;

   // Ops that complete without iterating jump straight from IDLE to DONE
`ifdef LAPIDO_MDU_DIV_EN
   assign w_fast        = bus.op[1] & (bus.op_b == '0);
   assign w_fast_result = bus.op[0] ? bus.op_a : {c_width{1'b1}};
`else
   assign w_fast        = bus.op[1];
   assign w_fast_result = '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = w_fast ? S_DONE : S_RUN;
         S_RUN:   if (r_cnt == c_last) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (bus.flush) w_state_nxt = S_IDLE;
   end

   // hi:lo is the product for MUL, remainder:quotient for DIV
   always_comb begin
      w_sum    = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_a : {c_width{1'b0}})};
      w_hi_nxt = w_sum[c_width:1];
      w_lo_nxt = {w_sum[0], r_lo[c_width-1:1]};
`ifdef LAPIDO_MDU_DIV_EN
      w_rem_sh = {r_hi, r_lo[c_width-1]};
      w_diff   = w_rem_sh - {1'b0, r_b};
      if (r_is_div) begin
         if (w_diff[c_width]) begin
            w_hi_nxt = w_rem_sh[c_width-1:0];
            w_lo_nxt = {r_lo[c_width-2:0], 1'b0};
         end else begin
            w_hi_nxt = w_diff[c_width-1:0];
            w_lo_nxt = {r_lo[c_width-2:0], 1'b1};
         end
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_sel_hi <= 1'b0;
         r_a      <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
`ifdef LAPIDO_MDU_DIV_EN
         r_b      <= '0;
         r_is_div <= 1'b0;
`endif
      end else if (w_accept) begin
         r_cnt    <= '0;
         r_sel_hi <= bus.op[0];
         r_a      <= bus.op_a;
         r_hi     <= '0;
`ifdef LAPIDO_MDU_DIV_EN
         r_b      <= bus.op_b;
         r_is_div <= bus.op[1];
         r_lo     <= bus.op[1] ? bus.op_a : bus.op_b;
`else
         r_lo     <= bus.op_b;
`endif
      end else if (r_state == S_RUN) begin
         r_cnt <= r_cnt + 6'd1;
         r_hi  <= w_hi_nxt;
         r_lo  <= w_lo_nxt;
      end
   end

   // MULH and REM both select the upper half of the shared register pair
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_result   <= '0;
         r_div_zero <= 1'b0;
         r_illegal  <= 1'b0;
      end else if (w_accept) begin
         r_div_zero <= 1'b0;
         r_illegal  <= 1'b0;
         if (w_fast) begin
            r_result <= w_fast_result;
`ifdef LAPIDO_MDU_DIV_EN
            r_div_zero <= 1'b1;
`else
            r_illegal  <= 1'b1;
`endif
         end
      end else if (w_finish) begin
         r_result <= r_sel_hi ? w_hi_nxt : w_lo_nxt;
      end
   end

   assign bus.stall      = ~rst & (w_accept | (r_state == S_RUN));
   assign bus.busy       = (r_state == S_RUN);
   assign bus.done       = (r_state == S_DONE);
   assign bus.result     = r_result;
   assign bus.div_zero   = r_div_zero;
   assign bus.illegal_op = r_illegal;

endmodule

`default_nettype wire
